// File: rtl/sifh_pkg.sv
// Shared definitions for the histogram phase controller:
// state encoding, default widths and RAM read latency.
package sifh_pkg;

   localparam int NB_DEF  = 10;
   localparam int NC_DEF  = 16;
   localparam int NE_DEF  = 24;
   localparam int RAM_LAT = 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_ACQ,
      ST_DRAIN,
      ST_READOUT,
      ST_DONE
   } state_t;

endpackage

// File: rtl/his_phase_ctrl_if.sv
// Event, histogram RAM and readout signals of his_phase_ctrl.
// master = controller side, slave = environment side.
interface his_phase_ctrl_if
   import sifh_pkg::*;
#(
   parameter int NB = NB_DEF,
   parameter int NC = NC_DEF
);
   logic          ev_valid;
   logic [NB-1:0] ev_addr;
   logic          ev_ready;

   logic [NB-1:0] ram_raddr;
   logic          ram_ren;
   logic [NC-1:0] ram_rdata;
   logic [NB-1:0] ram_waddr;
   logic          ram_wen;
   logic [NC-1:0] ram_wdata;

   logic          out_valid;
   logic          out_ready;
   logic [NB-1:0] out_addr;
   logic [NC-1:0] out_count;

   modport master (
      input  ev_valid, ev_addr, ram_rdata, out_ready,
      output ev_ready, ram_raddr, ram_ren,
      output ram_waddr, ram_wen, ram_wdata,
      output out_valid, out_addr, out_count
   );

   modport slave (
      output ev_valid, ev_addr, ram_rdata, out_ready,
      input  ev_ready, ram_raddr, ram_ren,
      input  ram_waddr, ram_wen, ram_wdata,
      input  out_valid, out_addr, out_count
   );

endinterface

// File: rtl/his_rmw_pipe.sv
// Two-stage read-modify-write bin incrementer with same-bin forwarding.
// HIS_SAT_EN: increment saturates at all-ones instead of wrapping.
module his_rmw_pipe
   import sifh_pkg::*;
#(
   parameter int NB = NB_DEF,
   parameter int NC = NC_DEF
) (
   input  logic          clk,
   input  logic          res,
   input  logic          flush,
   input  logic          in_valid,
   input  logic [NB-1:0] in_addr,
   output logic          rd_en,
   output logic [NB-1:0] rd_addr,
   input  logic [NC-1:0] rd_data,
   output logic          wr_en,
   output logic [NB-1:0] wr_addr,
   output logic [NC-1:0] wr_data
);

   logic          s1_vld_q, s1_vld_d;
   logic [NB-1:0] s1_addr_q, s1_addr_d;
   logic          lw_vld_q, lw_vld_d;
   logic [NB-1:0] lw_addr_q, lw_addr_d;
   logic [NC-1:0] lw_data_q, lw_data_d;
   logic [NC-1:0] old;

   // Read on accept; next cycle write old+1, old taken from the previous
   // write when it hit the same bin (RAM still returns pre-write data).
   always_comb begin
      rd_en     = in_valid;
      rd_addr   = in_valid ? in_addr : '0;
      s1_vld_d  = in_valid && !flush;
      s1_addr_d = in_addr;
      old       = rd_data;
      if (lw_vld_q && lw_addr_q == s1_addr_q) begin
         old = lw_data_q;
      end
      wr_en   = s1_vld_q && !flush;
      wr_addr = '0;
      wr_data = '0;
      if (wr_en) begin
         wr_addr = s1_addr_q;
`ifdef HIS_SAT_EN
         wr_data = (&old) ? old : old + NC'(1);
`else
         wr_data = old + NC'(1);
`endif
      end
      lw_vld_d  = wr_en;
      lw_addr_d = wr_addr;
      lw_data_d = wr_data;
   end

   // Pipeline stage and last-write forwarding registers.
   always_ff @(posedge clk) begin
      if (res) begin
         s1_vld_q  <= 1'b0;
         s1_addr_q <= '0;
         lw_vld_q  <= 1'b0;
         lw_addr_q <= '0;
         lw_data_q <= '0;
      end else begin
         s1_vld_q  <= s1_vld_d;
         s1_addr_q <= s1_addr_d;
         lw_vld_q  <= lw_vld_d;
         lw_addr_q <= lw_addr_d;
         lw_data_q <= lw_data_d;
      end
   end

endmodule

// File: rtl/his_phase_ctrl.sv
// Histogram run controller: clear, acquire, drain, readout, done.
// HIS_SAT_EN (in his_rmw_pipe) selects saturating bin increment.
module his_phase_ctrl
   import sifh_pkg::*;
#(
   parameter int NB = NB_DEF,
   parameter int NC = NC_DEF,
   parameter int NE = NE_DEF
) (
   input  logic             clk,
   input  logic             res,
   input  logic             start,
   input  logic             abort,
   input  logic [NE-1:0]    ev_num,
   his_phase_ctrl_if.master bus,
   output logic             busy,
   output logic             done
);

   localparam logic [NB-1:0] IDX_MAX = '1;

   state_t        state_q, state_d;
   logic [NB-1:0] idx_q, idx_d;
   logic [NE-1:0] cnt_q, cnt_d;
   logic [NE-1:0] num_q, num_d;
   logic [1:0]    drn_q, drn_d;
   logic          pend_q, pend_d;
   logic          ov_q, ov_d;
   logic [NB-1:0] oaddr_q, oaddr_d;
   logic [NC-1:0] ocnt_q, ocnt_d;

   logic          acc;
   logic          hs;
   logic          rd_issue;
   logic          clr_wen;
   logic          p_ren;
   logic [NB-1:0] p_raddr;
   logic          p_wen;
   logic [NB-1:0] p_waddr;
   logic [NC-1:0] p_wdata;

   // Phase sequencing, event counting and readout handshake.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      cnt_d    = cnt_q;
      num_d    = num_q;
      drn_d    = drn_q;
      pend_d   = 1'b0;
      ov_d     = ov_q;
      oaddr_d  = oaddr_q;
      ocnt_d   = ocnt_q;
      acc      = 1'b0;
      hs       = ov_q && bus.out_ready;
      rd_issue = 1'b0;
      clr_wen  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_CLEAR;
               idx_d   = '0;
               cnt_d   = '0;
               num_d   = ev_num;
            end
         end
         ST_CLEAR: begin
            clr_wen = 1'b1;
            idx_d   = idx_q + NB'(1);
            if (idx_q == IDX_MAX) begin
               state_d = (num_q == '0) ? ST_DRAIN : ST_ACQ;
               drn_d   = '0;
            end
         end
         ST_ACQ: begin
            acc = bus.ev_valid;
            if (acc) begin
               cnt_d = cnt_q + NE'(1);
               if (cnt_d == num_q) begin
                  state_d = ST_DRAIN;
                  drn_d   = '0;
               end
            end
         end
         ST_DRAIN: begin
            drn_d = drn_q + 2'd1;
            if (drn_q == 2'(RAM_LAT)) begin
               state_d = ST_READOUT;
               idx_d   = '0;
               ov_d    = 1'b0;
            end
         end
         ST_READOUT: begin
            rd_issue = !pend_q &&
                       (!ov_q || (hs && oaddr_q != IDX_MAX));
            pend_d = rd_issue;
            if (rd_issue) begin
               idx_d = idx_q + NB'(1);
            end
            if (pend_q) begin
               ov_d    = 1'b1;
               oaddr_d = idx_q - NB'(1);
               ocnt_d  = bus.ram_rdata;
            end else if (hs) begin
               ov_d = 1'b0;
               if (oaddr_q == IDX_MAX) begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      if (abort) begin
         state_d = ST_IDLE;
         ov_d    = 1'b0;
         pend_d  = 1'b0;
      end
   end

   // Controller state registers.
   always_ff @(posedge clk) begin
      if (res) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
         num_q   <= '0;
         drn_q   <= '0;
         pend_q  <= 1'b0;
         ov_q    <= 1'b0;
         oaddr_q <= '0;
         ocnt_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         num_q   <= num_d;
         drn_q   <= drn_d;
         pend_q  <= pend_d;
         ov_q    <= ov_d;
         oaddr_q <= oaddr_d;
         ocnt_q  <= ocnt_d;
      end
   end

   his_rmw_pipe #(
      .NB(NB),
      .NC(NC)
   ) u_rmw (
      .clk     (clk),
      .res     (res),
      .flush   (abort),
      .in_valid(acc),
      .in_addr (bus.ev_addr),
      .rd_en   (p_ren),
      .rd_addr (p_raddr),
      .rd_data (bus.ram_rdata),
      .wr_en   (p_wen),
      .wr_addr (p_waddr),
      .wr_data (p_wdata)
   );

   assign bus.ev_ready  = (state_q == ST_ACQ);
   assign bus.ram_ren   = p_ren || rd_issue;
   assign bus.ram_raddr = p_ren ? p_raddr :
                          (rd_issue ? idx_q : '0);
   assign bus.ram_wen   = clr_wen || p_wen;
   assign bus.ram_waddr = clr_wen ? idx_q : p_waddr;
   assign bus.ram_wdata = clr_wen ? '0 : p_wdata;
   assign bus.out_valid = ov_q;
   assign bus.out_addr  = oaddr_q;
   assign bus.out_count = ocnt_q;
   assign busy          = (state_q != ST_IDLE);
   assign done          = (state_q == ST_DONE);

endmodule

// File: tb/tb_his_phase_ctrl.sv
// Self-checking bench for his_phase_ctrl (NB=4, NC=8) with a
// 1-cycle-latency RAM model and a bin-counting reference model.
module tb_his_phase_ctrl;

   localparam int NB   = 4;
   localparam int NC   = 8;
   localparam int NE   = 16;
   localparam int NBIN = 1 << NB;
   localparam int CMAX = (1 << NC) - 1;

   typedef struct {
      int num;
      int a;
      int b;
      int ea;
      int eb;
   } vec_t;

   logic          clk = 1'b0;
   logic          res;
   logic          start;
   logic          abort;
   logic [NE-1:0] ev_num;
   logic          busy;
   logic          done;

   his_phase_ctrl_if #(.NB(NB), .NC(NC)) bus ();

   his_phase_ctrl #(.NB(NB), .NC(NC), .NE(NE)) dut (
      .clk   (clk),
      .res   (res),
      .start (start),
      .abort (abort),
      .ev_num(ev_num),
      .bus   (bus),
      .busy  (busy),
      .done  (done)
   );

   always #5 clk = ~clk;

   logic [NC-1:0] mem [NBIN];

   // RAM model: registered read, read-during-write returns old data;
   // filled with garbage while reset is held so CLEAR must matter.
   always @(posedge clk) begin
      if (res) begin
         for (int k = 0; k < NBIN; k++) mem[k] <= NC'($urandom);
      end else begin
         if (bus.ram_ren) bus.ram_rdata <= mem[bus.ram_raddr];
         if (bus.ram_wen) mem[bus.ram_waddr] <= bus.ram_wdata;
      end
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic int bump(input int v);
`ifdef HIS_SAT_EN
      return (v >= CMAX) ? CMAX : v + 1;
`else
      return (v + 1) % (CMAX + 1);
`endif
   endfunction

   task automatic cmp_bins(input string nm, input int got[NBIN],
                           input int exp[NBIN]);
      for (int k = 0; k < NBIN; k++)
         chk($sformatf("%s_bin%0d", nm, k), got[k], exp[k]);
   endtask

   task automatic run_case(input string nm, input int num,
                           input int addrs[$], input bit gaps,
                           input bit rnd_rdy, input int stall_bin,
                           output int got[NBIN]);
      for (int k = 0; k < NBIN; k++) got[k] = -1;
      ev_num = NE'(num);
      start  = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      ev_num = NE'($urandom);
      fork
         begin
            int i;
            int c;
            i = 0;
            c = 0;
            while (i < num && c < num * 4 + 400) begin
               bus.ev_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
               bus.ev_addr  = NB'(addrs[i]);
               #1;
               if (bus.ev_valid && bus.ev_ready) i++;
               @(negedge clk);
               c++;
            end
            chk({nm, "_ev_accepted"}, i, num);
            #1;
            if (num > 0) chk({nm, "_ev_ready_drop"}, bus.ev_ready, 0);
            bus.ev_valid = 1'b1;
            bus.ev_addr  = NB'($urandom);
         end
         begin
            bit clr_ok, ord_ok, tput_ok, st_ok, seen;
            int nxt, stall_n, last_hs, cyc;
            bit stall;
            logic [NB-1:0] s_addr;
            logic [NC-1:0] s_cnt;
            chk({nm, "_busy_run"}, busy, 1);
            clr_ok = 1'b1;
            for (int k = 0; k < NBIN; k++) begin
               if (!(bus.ram_wen === 1'b1 && bus.ram_waddr === NB'(k) &&
                     bus.ram_wdata === '0)) clr_ok = 1'b0;
               @(negedge clk);
            end
            if (bus.ram_wen !== 1'b0) clr_ok = 1'b0;
            chk({nm, "_clear_seq"}, clr_ok, 1);
            nxt = 0; stall_n = 0; last_hs = -1; cyc = 0;
            ord_ok = 1'b1; tput_ok = 1'b1; st_ok = 1'b1; seen = 1'b0;
            s_addr = '0; s_cnt = '0;
            while (!seen && cyc < num * 4 + 2000) begin
               start = (cyc == 3);
               stall = bus.out_valid && stall_bin >= 0 &&
                       int'(bus.out_addr) == stall_bin && stall_n < 10;
               if (stall) bus.out_ready = 1'b0;
               else bus.out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
               #1;
               if (stall) begin
                  if (stall_n == 0) begin
                     s_addr = bus.out_addr;
                     s_cnt  = bus.out_count;
                  end else if (bus.out_addr !== s_addr ||
                               bus.out_count !== s_cnt) st_ok = 1'b0;
                  if (bus.ram_ren !== 1'b0) st_ok = 1'b0;
                  stall_n++;
               end
               if (done) seen = 1'b1;
               if (bus.out_valid && bus.out_ready) begin
                  if (int'(bus.out_addr) != nxt) ord_ok = 1'b0;
                  if (nxt < NBIN) got[nxt] = int'(bus.out_count);
                  if (last_hs >= 0 && cyc - last_hs != 2) tput_ok = 1'b0;
                  last_hs = cyc;
                  nxt++;
               end
               @(negedge clk);
               cyc++;
            end
            start = 1'b0;
            chk({nm, "_order"}, ord_ok, 1);
            chk({nm, "_nbins"}, nxt, NBIN);
            chk({nm, "_done_seen"}, seen, 1);
            chk({nm, "_done_pulse"}, done, 0);
            chk({nm, "_busy_after"}, busy, 0);
            if (!rnd_rdy && stall_bin < 0)
               chk({nm, "_throughput"}, tput_ok, 1);
            if (stall_bin >= 0) begin
               chk({nm, "_stall_stable"}, st_ok, 1);
               chk({nm, "_stall_len"}, stall_n, 10);
            end
         end
      join
      bus.ev_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
   endtask

   vec_t tbl[6];
   int   q[$];
   int   g[NBIN];
   int   e[NBIN];
   int   n, prev, a, acc_n, cyc_n;
   bit   dflag;

   initial begin
      tbl[0] = '{num: 0,   a: 0,  b: 0,  ea: 0, eb: 0};
      tbl[1] = '{num: 5,   a: 3,  b: 3,  ea: 5, eb: 5};
      tbl[2] = '{num: 4,   a: 2,  b: 7,  ea: 2, eb: 2};
`ifdef HIS_SAT_EN
      tbl[3] = '{num: 300, a: 1,  b: 1,  ea: 255, eb: 255};
`else
      tbl[3] = '{num: 300, a: 1,  b: 1,  ea: 44,  eb: 44};
`endif
      tbl[4] = '{num: 1,   a: 15, b: 15, ea: 1, eb: 1};
      tbl[5] = '{num: 3,   a: 0,  b: 15, ea: 2, eb: 1};

      res = 1'b1; start = 1'b1; abort = 1'b1; ev_num = '1;
      bus.ev_valid = 1'b1; bus.ev_addr = '0; bus.out_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_ev_ready", bus.ev_ready, 0);
      chk("rst_ren", bus.ram_ren, 0);
      chk("rst_raddr", bus.ram_raddr, 0);
      chk("rst_wen", bus.ram_wen, 0);
      chk("rst_waddr", bus.ram_waddr, 0);
      chk("rst_wdata", bus.ram_wdata, 0);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_addr", bus.out_addr, 0);
      chk("rst_out_count", bus.out_count, 0);
      start = 1'b0; abort = 1'b0; bus.ev_valid = 1'b0;
      res = 1'b0;
      @(negedge clk);
      chk("rst_release_idle", busy, 0);

      for (int v = 0; v < 6; v++) begin
         q.delete();
         for (int i = 0; i < tbl[v].num; i++)
            q.push_back((i % 2) ? tbl[v].b : tbl[v].a);
         run_case($sformatf("vec%0d", v), tbl[v].num, q, 1'b0, 1'b0, -1, g);
         for (int k = 0; k < NBIN; k++) e[k] = 0;
         e[tbl[v].a] = tbl[v].ea;
         e[tbl[v].b] = tbl[v].eb;
         cmp_bins($sformatf("vec%0d", v), g, e);
      end

      q.delete();
      q.push_back(6); q.push_back(6); q.push_back(7); q.push_back(2);
      run_case("stall", 4, q, 1'b0, 1'b0, 6, g);
      for (int k = 0; k < NBIN; k++) e[k] = 0;
      e[6] = 2; e[7] = 1; e[2] = 1;
      cmp_bins("stall", g, e);

      start = 1'b1; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      chk("start_abort_idle", busy, 0);
      repeat (3) @(negedge clk);
      chk("start_abort_stay", busy, 0);

      ev_num = 16'd10; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      bus.ev_valid = 1'b1; bus.ev_addr = 4'd5;
      acc_n = 0; cyc_n = 0;
      while (acc_n < 2 && cyc_n < 100) begin
         #1;
         if (bus.ev_ready) acc_n++;
         @(negedge clk);
         cyc_n++;
      end
      chk("abort_acc", acc_n, 2);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_ev_ready", bus.ev_ready, 0);
      chk("abort_wen", bus.ram_wen, 0);
      chk("abort_ren", bus.ram_ren, 0);
      chk("abort_out_valid", bus.out_valid, 0);
      bus.ev_valid = 1'b0;
      dflag = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (done || busy) dflag = 1'b1;
      end
      chk("abort_no_done", dflag, 0);
      q.delete();
      q.push_back(5); q.push_back(5); q.push_back(9);
      run_case("post_abort", 3, q, 1'b0, 1'b0, -1, g);
      for (int k = 0; k < NBIN; k++) e[k] = 0;
      e[5] = 2; e[9] = 1;
      cmp_bins("post_abort", g, e);

      ev_num = 16'd5; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      res = 1'b1;
      @(negedge clk);
      res = 1'b0;
      chk("midrun_rst_busy", busy, 0);
      chk("midrun_rst_wen", bus.ram_wen, 0);

      for (int r = 0; r < 6; r++) begin
         q.delete();
         n = $urandom_range(0, 40);
         prev = $urandom_range(0, NBIN - 1);
         for (int i = 0; i < n; i++) begin
            a = ($urandom_range(0, 1) != 0) ? prev :
                $urandom_range(0, NBIN - 1);
            q.push_back(a);
            prev = a;
         end
         for (int k = 0; k < NBIN; k++) e[k] = 0;
         foreach (q[i]) e[q[i]] = bump(e[q[i]]);
         run_case($sformatf("rnd%0d", r), n, q, 1'b1, 1'b1, -1, g);
         cmp_bins($sformatf("rnd%0d", r), g, e);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/his_phase_ctrl.md
HIS_PHASE_CTRL -- requirements
Module: his_phase_ctrl

Interface
REQ-001 SHALL have parameter NB, default 10: histogram address width, 2^NB bins.
REQ-002 SHALL have parameter NC, default 16: bin count width.
REQ-003 SHALL have parameter NE, default 24: event-count width.
REQ-004 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- res  in  1  reset, synchronous, active-high.
- start  in  1  begin a clear/acquire/readout run.
- abort  in  1  terminate the run.
- ev_num  in  NE  events per run, sampled on accepted start.
- ev_valid  in  1  event present.
- ev_addr  in  NB  event bin.
- ev_ready  out  1  event accepted when high with ev_valid.
- ram_raddr  out  NB  RAM port B address.
- ram_ren  out  1  port B read enable.
- ram_rdata  in  NC  port B data, valid 1 cycle after ram_ren.
- ram_waddr  out  NB  RAM port A address.
- ram_wen  out  1  port A write enable.
- ram_wdata  out  NC  port A data.
- out_valid  out  1  readout bin valid.
- out_ready  in  1  readout consumer ready.
- out_addr  out  NB  readout bin index.
- out_count  out  NC  readout bin count.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at readout completion.

Function
REQ-005 SHALL implement states IDLE, CLEAR, ACQ, DRAIN, READOUT, DONE.
REQ-006 IDLE->CLEAR on start; start outside IDLE SHALL be ignored.
REQ-007 CLEAR SHALL write 0 to addresses 0..2^NB-1, one per cycle, ascending, then go to ACQ; duration exactly 2^NB cycles.
REQ-008 ACQ SHALL hold ev_ready=1 while accepted events < ev_num; on the cycle accepting event ev_num, ev_ready SHALL drop on the next cycle and state SHALL become DRAIN.
REQ-009 ev_num=0 SHALL skip ACQ: CLEAR->DRAIN.
REQ-010 Accepted event at cycle t SHALL drive ram_ren=1, ram_raddr=ev_addr at t; at t+1 ram_wen=1, ram_waddr=ev_addr, ram_wdata=old+1.
REQ-011 RAM read-during-write returns old data; when the event at t+1 hits the same bin as the event at t, old SHALL be forwarded from the t write data, never ram_rdata; N back-to-back same-bin events SHALL increase that bin by exactly N.
REQ-012 DRAIN SHALL last 2 cycles, then READOUT.
REQ-013 READOUT SHALL read bins 0..2^NB-1 ascending; each read's data SHALL be registered into out_count/out_addr with out_valid=1 the following cycle, held stable until out_valid&out_ready; next read issued only after the handshake; peak throughput one bin per 2 cycles.
REQ-014 After handshake of bin 2^NB-1, state SHALL go DONE for one cycle (done=1), then IDLE.
REQ-015 abort in any non-IDLE state SHALL force IDLE next cycle; ram_wen, ram_ren, out_valid, ev_ready SHALL be 0 from that cycle; an in-flight increment write SHALL be dropped.
REQ-016 abort and start in the same IDLE cycle: abort wins, no run starts.
REQ-017 Outside ACQ, ev_ready SHALL be 0; events presented are not consumed.

Reset
REQ-018 On res all outputs SHALL be 0, state IDLE, counters 0; res overrides abort and start.

Configuration
REQ-019 With HIS_SAT_EN defined, increment SHALL saturate at 2^NC-1; without it, increment SHALL wrap modulo 2^NC.

Structure
REQ-020 State encoding, NB/NC/NE defaults and RAM latency constant (1) SHALL live in shared package sifh_pkg.
REQ-021 The read-modify-write pipeline with forwarding and saturation SHALL be sub-module his_rmw_pipe; FSM, counters and readout stay in his_phase_ctrl.

Verification (NB=4, NC=8, bench RAM model with 1-cycle read latency)
REQ-022 start, ev_num=0 -> 16 zero writes addr 0..15, DRAIN, 16 readouts all count 0, done pulse, busy low after.
REQ-023 ev_num=5, events bins 3,3,3,3,3 back-to-back -> readout bin 3 = 5, all others 0.
REQ-024 ev_num=4, bins 2,7,2,7 back-to-back -> bins 2 and 7 = 2; ev_ready low after 4th event.
REQ-025 HIS_SAT_EN, ev_num=300, all bin 1 -> bin 1 = 255; without macro -> bin 1 = 44.
REQ-026 out_ready low for 10 cycles during bin 6 -> out_count/out_addr stable, no read issued, bin 7 follows after handshake.
REQ-027 abort during ACQ after 2 events -> IDLE next cycle, all enables 0, no done; new start re-clears and counts correctly.
